// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//   Shared constants for the program loader: byte/word geometry, instruction
//   field positions, FSM state encodings and the instruction format check.
//   No ports (package).
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  // Stream and word geometry. An instruction word is always four bytes.
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int INSN_W         = BYTES_PER_WORD * BYTE_W;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // Instruction field positions.
  localparam int VALUE_LSB = 0;
  localparam int VALUE_W   = 16;
  localparam int DEST_LSB  = 16;
  localparam int SRC_LSB   = 18;
  localparam int ADD_BIT   = 20;
  localparam int JUMP_BIT  = 21;
  localparam int RSVD_LSB  = 22;

  // Loader FSM encodings, kept as plain constants so the state register can
  // be probed or forced by older tooling that does not understand enums.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HDR     = 3'd1;
  localparam state_t ST_COLLECT = 3'd2;
  localparam state_t ST_CHECK   = 3'd3;
  localparam state_t ST_WRITE   = 3'd4;
  localparam state_t ST_DONE    = 3'd5;
  localparam state_t ST_ERR     = 3'd6;

  // A word is loadable when its reserved bits are clear and it does not ask
  // for add and jump at the same time (the processor cannot do both).
  function automatic logic insn_format_ok(input logic [INSN_W-1:0] word);
    return (word[INSN_W-1:RSVD_LSB] == '0) && !(word[ADD_BIT] && word[JUMP_BIT]);
  endfunction

endpackage : prog_loader_pkg

// File: rtl/prog_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// prog_loader_word_assembler
//   Little-endian 4-byte shift register. Each load shifts the new byte in at
//   the top, so after four loads the first byte received sits in [7:0].
//
//   clk          in   clock, rising edge active
//   rst_n        in   asynchronous active-low reset
//   clear_i      in   restart the byte index (wins over load_i)
//   load_i       in   shift byte_i into the word this cycle
//   byte_i       in   stream byte
//   word_o       out  assembled word
//   word_full_o  out  the byte loaded this cycle completes the word
// -----------------------------------------------------------------------------
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [INSN_W-1:0] word_o,
  output logic              word_full_o
);

  logic [INSN_W-1:0]     word_q;
  logic [BYTE_IDX_W-1:0] idx_q;

  // The index is a power-of-two counter, so it naturally returns to 0 after
  // the last byte of a word; clear_i covers restarts in the middle of a word.
  assign word_full_o = load_i && !clear_i && (idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign word_o      = word_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
    end else if (load_i) begin
      word_q <= {byte_i, word_q[INSN_W-1:BYTE_W]};
      idx_q  <= idx_q + 1'b1;
    end
  end

endmodule : prog_loader_word_assembler

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Receives a byte stream from the host link, assembles 32-bit instruction
//   words, validates them and writes them sequentially into the program store
//   while holding the processor in programming mode.
//
//   Stream format: one header byte N (word count, 1..DEPTH), then N words of
//   four bytes each, least significant byte first.
//
//   advance       in   clock, rising edge active
//   rst_n         in   asynchronous active-low reset
//   start         in   one-cycle pulse, begins a new load session
//   byte_in       in   stream data
//   byte_valid    in   byte_in is valid
//   byte_ready    out  loader accepts byte_in this cycle
//   wr_en         out  program store write strobe, one cycle per word
//   wr_addr       out  program store address
//   wr_data       out  instruction word
//   prog          out  processor programming mode
//   done          out  load completed successfully (level)
//   err           out  load aborted on a protocol or format error (level)
//   words_loaded  out  words written in this session
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,   // 2**ADDR_W must equal DEPTH
  parameter int WORD_W = 32   // fixed at four bytes
) (
  input  logic              advance,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              prog,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [ADDR_W:0]     count_q,   count_d;
  logic [ADDR_W:0]     n_q,       n_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;

  // Assembler interface
  logic                asm_clear;
  logic                asm_load;
  logic [INSN_W-1:0]   asm_word;
  logic                asm_full;

  // Helpers
  logic                byte_accept;
  logic                hdr_ok;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W-1:0]   addr_inc;

  // ---------------------------------------------------------------------------
  // Word assembler
  // ---------------------------------------------------------------------------
  prog_loader_word_assembler u_word_assembler (
    .clk         (advance),
    .rst_n       (rst_n),
    .clear_i     (asm_clear),
    .load_i      (asm_load),
    .byte_i      (byte_in),
    .word_o      (asm_word),
    .word_full_o (asm_full)
  );

  // ---------------------------------------------------------------------------
  // Handshake and arithmetic helpers
  // ---------------------------------------------------------------------------
  // start masks ready so a byte presented alongside a restart is not consumed
  // by the session being abandoned; the source holds it for the new header.
  assign byte_ready  = ((state_q == ST_HDR) || (state_q == ST_COLLECT)) && !start;
  assign byte_accept = byte_ready && byte_valid;

  assign hdr_ok    = (byte_in != '0) && (int'(byte_in) <= DEPTH);
  assign count_inc = count_q + 1'b1;

  // The header limit keeps the final write at DEPTH-1; saturating here keeps
  // wr_addr on the last written entry instead of wrapping to 0 afterwards.
  assign addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? addr_q : addr_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    n_d       = n_q;
    wr_data_d = wr_data_q;
    asm_clear = 1'b0;
    asm_load  = 1'b0;

    if (start) begin
      // Restart from any state, including mid-word.
      state_d   = ST_HDR;
      addr_d    = '0;
      count_d   = '0;
      asm_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_HDR: begin
          if (byte_accept) begin
            if (hdr_ok) begin
              n_d     = byte_in[ADDR_W:0];
              state_d = ST_COLLECT;
            end else begin
              state_d = ST_ERR;
            end
          end
        end

        ST_COLLECT: begin
          asm_load = byte_accept;
          if (asm_full) state_d = ST_CHECK;
        end

        ST_CHECK: begin
          // Capture only good words, so wr_data keeps the last written word
          // when a load aborts.
          if (insn_format_ok(asm_word)) begin
            wr_data_d = asm_word;
            state_d   = ST_WRITE;
          end else begin
            state_d   = ST_ERR;
          end
        end

        ST_WRITE: begin
          addr_d    = addr_inc;
          count_d   = count_inc;
          asm_clear = 1'b1;
          state_d   = (count_inc == n_q) ? ST_DONE : ST_COLLECT;
        end

        ST_DONE, ST_ERR: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge advance or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      n_q       <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      n_q       <= n_d;
      wr_data_q <= wr_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state, so reset clears them at once)
  // ---------------------------------------------------------------------------
  assign wr_en        = (state_q == ST_WRITE);
  assign wr_addr      = addr_q;
  assign wr_data      = wr_data_q;
  assign prog         = (state_q == ST_HDR)   || (state_q == ST_COLLECT) ||
                        (state_q == ST_CHECK) || (state_q == ST_WRITE);
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign words_loaded = count_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader: table of complete load sessions plus
//   hand-written restart, full-depth and asynchronous-reset sequences.
//   Expected program store writes go into a scoreboard queue as stimulus is
//   issued and are popped as the DUT strobes wr_en.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  logic        advance;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        prog;
  logic        done;
  logic        err;
  logic [4:0]  words_loaded;

  prog_loader dut (
    .advance      (advance),
    .rst_n        (rst_n),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .prog         (prog),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial advance = 1'b0;
  always #5 advance = ~advance;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard of expected program store writes
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];

  always @(negedge advance) begin
    if (rst_n && wr_en) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got write addr=%0d data=0x%08h, expected none",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {28'b0, wr_addr}, {28'b0, e.addr});
        check("wr_data", wr_data, e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge advance);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit got;
    if (stall) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge advance);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    got        = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (byte_ready) got = 1'b1;
      @(posedge advance);
      @(negedge advance);
    end
    byte_valid = 1'b0;
    if (!got) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (done || err) seen = 1'b1;
      else @(negedge advance);
    end
    if (!seen) check("end_timeout", 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Session vectors: stream bytes are packed LSB-first, byte i at [8i+:8]
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [7:0]  hdr;
    int          nbytes;
    logic [63:0] bytes;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
    logic [4:0]  exp_loaded;
    logic [3:0]  exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int wr_before;

    vecs[0] = '{"basic",     8'h02, 8, 64'h0015000A_00100005, 2, 32'h00100005, 32'h0015000A, 1'b1, 1'b0, 5'd2, 4'd2};
    vecs[1] = '{"jump",      8'h01, 4, 64'h00000000_00200002, 1, 32'h00200002, 32'h0,        1'b1, 1'b0, 5'd1, 4'd1};
    vecs[2] = '{"hdr_zero",  8'h00, 0, 64'h0,                 0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 4'd0};
    vecs[3] = '{"hdr_17",    8'h11, 0, 64'h0,                 0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 4'd0};
    vecs[4] = '{"add_jump",  8'h01, 4, 64'h00000000_00300005, 0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 4'd0};
    vecs[5] = '{"reserved",  8'h01, 4, 64'h00000000_00400000, 0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 4'd0};
    vecs[6] = '{"err_word2", 8'h02, 8, 64'h80000000_00000001, 1, 32'h00000001, 32'h0,        1'b0, 1'b1, 5'd1, 4'd1};
    vecs[7] = '{"fields",    8'h01, 4, 64'h00000000_001FFFFF, 1, 32'h001FFFFF, 32'h0,        1'b1, 1'b0, 5'd1, 4'd1};

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge advance);
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("rst_prog",       {31'b0, prog},       32'd0);
    check("rst_done",       {31'b0, done},       32'd0);
    check("rst_err",        {31'b0, err},        32'd0);
    check("rst_wr_en",      {31'b0, wr_en},      32'd0);
    check("rst_loaded",     {27'b0, words_loaded}, 32'd0);
    check("rst_wr_data",    wr_data,             32'd0);
    rst_n = 1'b1;
    @(negedge advance);
    check("idle_byte_ready", {31'b0, byte_ready}, 32'd0);

    // Table-driven sessions
    for (int v = 0; v < 8; v++) begin
      wr_before = n_writes;
      if (v == 0) sb_q.push_back('{addr: 4'd0, data: vecs[v].w0});
      else if (vecs[v].nwr >= 1) sb_q.push_back('{addr: 4'd0, data: vecs[v].w0});
      if (vecs[v].nwr >= 2) sb_q.push_back('{addr: 4'd1, data: vecs[v].w1});
      pulse_start();
      #1;
      check({vecs[v].name, "_hdr_prog"},  {31'b0, prog},       32'd1);
      check({vecs[v].name, "_hdr_ready"}, {31'b0, byte_ready}, 32'd1);
      send_byte(vecs[v].hdr, 1'b0);
      for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].bytes[8*i +: 8], 1'b0);
      wait_end();
      repeat (2) @(negedge advance);
      check({vecs[v].name, "_done"},   {31'b0, done},          {31'b0, vecs[v].exp_done});
      check({vecs[v].name, "_err"},    {31'b0, err},           {31'b0, vecs[v].exp_err});
      check({vecs[v].name, "_prog"},   {31'b0, prog},          32'd0);
      check({vecs[v].name, "_loaded"}, {27'b0, words_loaded},  {27'b0, vecs[v].exp_loaded});
      check({vecs[v].name, "_addr"},   {28'b0, wr_addr},       {28'b0, vecs[v].exp_addr});
      check({vecs[v].name, "_nwr"},    n_writes - wr_before,   vecs[v].nwr);
      check({vecs[v].name, "_sb"},     sb_q.size(),            32'd0);
    end

    // Full depth with random source stalls
    begin
      logic [31:0] w;
      wr_before = n_writes;
      pulse_start();
      send_byte(8'h10, 1'b1);
      for (int i = 0; i < 16; i++) begin
        logic [3:0] iv;
        iv = 4'(i);
        w  = {10'b0, 1'b0, iv[0], iv[3:2], iv[1:0], 16'hA000 + 16'(i)};
        sb_q.push_back('{addr: iv, data: w});
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b1);
      end
      wait_end();
      @(negedge advance);
      check("full_done",   {31'b0, done},         32'd1);
      check("full_err",    {31'b0, err},          32'd0);
      check("full_loaded", {27'b0, words_loaded}, 32'd16);
      check("full_addr",   {28'b0, wr_addr},      32'd15);
      check("full_nwr",    n_writes - wr_before,  32'd16);
      check("full_sb",     sb_q.size(),           32'd0);
    end

    // Restart mid-word with a byte offered in the start cycle
    wr_before = n_writes;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    start      = 1'b1;
    byte_in    = 8'h10;
    byte_valid = 1'b1;
    #1;
    check("restart_ready_masked", {31'b0, byte_ready}, 32'd0);
    @(negedge advance);
    start      = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("restart_loaded", {27'b0, words_loaded}, 32'd0);
    check("restart_prog",   {31'b0, prog},         32'd1);
    check("restart_ready",  {31'b0, byte_ready},   32'd1);
    check("restart_done",   {31'b0, done},         32'd0);
    sb_q.push_back('{addr: 4'd0, data: 32'h00100005});
    send_byte(8'h01, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    @(negedge advance);
    check("restart_end_done",   {31'b0, done},         32'd1);
    check("restart_end_loaded", {27'b0, words_loaded}, 32'd1);
    check("restart_nwr",        n_writes - wr_before,  32'd1);

    // Asynchronous reset in the middle of a word
    wr_before = n_writes;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_prog",    {31'b0, prog},         32'd0);
    check("arst_ready",   {31'b0, byte_ready},   32'd0);
    check("arst_wr_en",   {31'b0, wr_en},        32'd0);
    check("arst_done",    {31'b0, done},         32'd0);
    check("arst_err",     {31'b0, err},          32'd0);
    check("arst_loaded",  {27'b0, words_loaded}, 32'd0);
    check("arst_wr_data", wr_data,               32'd0);
    @(negedge advance);
    rst_n      = 1'b1;
    byte_in    = 8'h10;
    byte_valid = 1'b1;
    repeat (10) @(negedge advance);
    byte_valid = 1'b0;
    check("arst_idle_ready", {31'b0, byte_ready}, 32'd0);
    check("arst_nwr",        n_writes - wr_before, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

endmodule : tb_prog_loader
